// File: rtl/prbs31_checker_if.sv
// prbs31_checker_if: RX word input and BER status bundle for the PRBS31 checker
interface prbs31_checker_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              clr;
    logic              locked;
    logic              err_pulse;
    logic [31:0]       bit_err_cnt;
    logic [31:0]       err_word_cnt;
    logic [47:0]       word_cnt;
    modport master (output din, din_vld, clr, input locked, err_pulse, bit_err_cnt, err_word_cnt, word_cnt);
    modport slave (input din, din_vld, clr, output locked, err_pulse, bit_err_cnt, err_word_cnt, word_cnt);
endinterface

// File: rtl/prbs31_checker.sv
// prbs31_checker: self-synchronising PRBS31 (x^31+x^28+1) receiver with saturating BER counters
module prbs31_checker #(
    parameter int DATA_W       = 32,
    parameter int LOCK_WORDS   = 16,
    parameter int UNLOCK_WORDS = 8
) (
    input logic             clk,
    input logic             rst,
    prbs31_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_WORDS + 1);
    localparam int BW = $clog2(UNLOCK_WORDS + 1);
    localparam int EW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ref_q, ref_d, exp_w;
    logic [MW-1:0]     match_cnt_q, match_cnt_d;
    logic [BW-1:0]     bad_cnt_q, bad_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic [31:0]       bit_err_cnt_q, bit_err_cnt_d;
    logic [31:0]       err_word_cnt_q, err_word_cnt_d;
    logic [47:0]       word_cnt_q, word_cnt_d;
    logic [EW-1:0]     e;
    logic [32:0]       bit_sum;

    // Bit j of the extended vector is s[base+j]; the upper half is the following word.
    function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w);
        logic [2*DATA_W-1:0] x;
        x = {{DATA_W{1'b0}}, w};
        for (int j = DATA_W; j < 2 * DATA_W; j++) x[j] = x[j-31] ^ x[j-28];
        return x[2*DATA_W-1:DATA_W];
    endfunction

    always_comb begin
        exp_w = next_word(ref_q);
        e = '0;
        for (int i = 0; i < DATA_W; i++) e = e + EW'(bus.din[i] ^ exp_w[i]);
        bit_sum        = {1'b0, bit_err_cnt_q} + 33'(e);
        state_d        = state_q;
        ref_d          = ref_q;
        match_cnt_d    = match_cnt_q;
        bad_cnt_d      = bad_cnt_q;
        err_pulse_d    = 1'b0;
        bit_err_cnt_d  = bit_err_cnt_q;
        err_word_cnt_d = err_word_cnt_q;
        word_cnt_d     = word_cnt_q;
        if (bus.din_vld) begin
            case (state_q)
                HUNT: if (bus.din != '0) begin
                    ref_d       = bus.din;
                    match_cnt_d = '0;
                    state_d     = SYNC;
                end
                SYNC: begin
                    ref_d = bus.din;
                    if (bus.din == exp_w && bus.din != '0) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == MW'(LOCK_WORDS)) begin
                            state_d   = LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else match_cnt_d = '0;
                end
                default: begin
                    ref_d      = exp_w;
                    word_cnt_d = &word_cnt_q ? word_cnt_q : word_cnt_q + 1'b1;
                    if (e != '0) begin
                        err_pulse_d    = 1'b1;
                        bit_err_cnt_d  = bit_sum[32] ? '1 : bit_sum[31:0];
                        err_word_cnt_d = &err_word_cnt_q ? err_word_cnt_q : err_word_cnt_q + 1'b1;
                        bad_cnt_d      = bad_cnt_q + 1'b1;
                        state_d        = bad_cnt_d == BW'(UNLOCK_WORDS) ? HUNT : LOCKED;
                    end else bad_cnt_d = '0;
                end
            endcase
        end
        if (bus.clr) begin
            bit_err_cnt_d  = '0;
            err_word_cnt_d = '0;
            word_cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HUNT;
            ref_q          <= '0;
            match_cnt_q    <= '0;
            bad_cnt_q      <= '0;
            err_pulse_q    <= 1'b0;
            bit_err_cnt_q  <= '0;
            err_word_cnt_q <= '0;
            word_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            ref_q          <= ref_d;
            match_cnt_q    <= match_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            err_pulse_q    <= err_pulse_d;
            bit_err_cnt_q  <= bit_err_cnt_d;
            err_word_cnt_q <= err_word_cnt_d;
            word_cnt_q     <= word_cnt_d;
        end
    end

    assign bus.locked       = state_q == LOCKED;
    assign bus.err_pulse    = err_pulse_q;
    assign bus.bit_err_cnt  = bit_err_cnt_q;
    assign bus.err_word_cnt = err_word_cnt_q;
    assign bus.word_cnt     = word_cnt_q;
endmodule

// File: tb/tb_prbs31_checker.sv
// tb_prbs31_checker: segment table plus per-cycle scoreboard against a stream-aware behavioural model
module tb_prbs31_checker;
    localparam int LOCK_WORDS   = 16;
    localparam int UNLOCK_WORDS = 8;

    typedef struct {
        logic        lk;
        logic        pl;
        logic [31:0] b;
        logic [31:0] w;
        logic [47:0] wc;
    } exp_t;

    typedef struct {
        string  name;
        int     n;
        bit     gap;
        int     kind;
        bit     clr;
        bit     lk;
        bit     pl;
        longint b;
        longint w;
        longint wc;
    } seg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs31_checker_if #(.DATA_W(32)) bus ();
    prbs31_checker #(.DATA_W(32), .LOCK_WORDS(LOCK_WORDS), .UNLOCK_WORDS(UNLOCK_WORDS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int     checks = 0;
    int     errors = 0;
    exp_t   sbq[$];
    logic [30:0] h = '1;
    int     ms = 0, mmatch = 0, mbad = 0;
    bit     mpl = 0, prev_clean = 0;
    longint mb = 0, mw = 0, mwc = 0;
    seg_t   tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Bit-serial reference stream: emit the oldest bit, append s[n+31] = s[n]^s[n+3].
    task automatic gen(output logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            w[i] = h[0];
            h = {h[0] ^ h[3], h[30:1]};
        end
    endtask

    task automatic step(input bit r, input bit v, input bit zero, input logic [31:0] mask, input bit c);
        logic [31:0] gw, d;
        bit          clean;
        int          e;
        exp_t        x;
        @(negedge clk);
        gw = '0;
        d = $urandom();
        if (v && !zero) begin
            gen(gw);
            d = gw ^ mask;
        end else if (v) d = '0;
        clean = v && !zero && mask == '0;
        rst = r;
        bus.din_vld = v;
        bus.din = d;
        bus.clr = c;
        mpl = 0;
        if (r) begin
            ms = 0; mmatch = 0; mbad = 0; prev_clean = 0;
            mb = 0; mw = 0; mwc = 0;
        end else begin
            if (v) begin
                if (ms == 0) begin
                    if (d != 0) begin ms = 1; mmatch = 0; end
                end else if (ms == 1) begin
                    if (clean && prev_clean) begin
                        mmatch++;
                        if (mmatch == LOCK_WORDS) begin ms = 2; mbad = 0; end
                    end else mmatch = 0;
                end else begin
                    e = $countones(d ^ gw);
                    mwc = (mwc + 1 > 64'hFFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF : mwc + 1;
                    if (e > 0) begin
                        mpl = 1;
                        mb = (mb + e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mb + e;
                        mw = (mw + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mw + 1;
                        mbad++;
                        if (mbad == UNLOCK_WORDS) ms = 0;
                    end else mbad = 0;
                end
                prev_clean = clean;
            end
            if (c) begin mb = 0; mw = 0; mwc = 0; end
        end
        x.lk = (ms == 2); x.pl = mpl; x.b = mb[31:0]; x.w = mw[31:0]; x.wc = mwc[47:0];
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk("locked", {63'd0, bus.locked}, {63'd0, x.lk});
        chk("err_pulse", {63'd0, bus.err_pulse}, {63'd0, x.pl});
        chk("bit_err_cnt", {32'd0, bus.bit_err_cnt}, {32'd0, x.b});
        chk("err_word_cnt", {32'd0, bus.err_word_cnt}, {32'd0, x.w});
        chk("word_cnt", {16'd0, bus.word_cnt}, {16'd0, x.wc});
    endtask

    function automatic logic [31:0] kind_mask(input int k);
        return k == 1 ? 32'h0000_0020 : k == 2 ? 32'h8000_0081 : k == 3 ? ($urandom() | 32'h1) : 32'h0;
    endfunction

    initial begin
        tbl[0]  = '{"pre_lock",    16, 0, 0, 0, 0, 0,  0,  0,  0};
        tbl[1]  = '{"lock",         1, 0, 0, 0, 1, 0,  0,  0,  0};
        tbl[2]  = '{"locked_run",   3, 0, 0, 0, 1, 0,  0,  0,  3};
        tbl[3]  = '{"err_bit5",     1, 0, 1, 0, 1, 1,  1,  1,  4};
        tbl[4]  = '{"no_absorb1",   2, 0, 0, 0, 1, 0,  1,  1,  6};
        tbl[5]  = '{"err_3bits",    1, 0, 2, 0, 1, 1,  4,  2,  7};
        tbl[6]  = '{"no_absorb2",   2, 0, 0, 0, 1, 0,  4,  2,  9};
        tbl[7]  = '{"bad7",         7, 0, 3, 0, 1, 1, -1,  9, 16};
        tbl[8]  = '{"bad8_unlock",  1, 0, 3, 0, 0, 1, -1, 10, 17};
        tbl[9]  = '{"relock_pre",  16, 0, 0, 0, 0, 0, -1, 10, 17};
        tbl[10] = '{"relock",       1, 0, 0, 0, 1, 0, -1, 10, 17};
        tbl[11] = '{"clr_collide",  1, 0, 1, 1, 1, 1,  0,  0,  0};
        tbl[12] = '{"post_clr",     2, 0, 0, 0, 1, 0,  0,  0,  2};
        tbl[13] = '{"unlock2",      8, 0, 3, 0, 0, 1, -1,  8, 10};
        tbl[14] = '{"gap_pre",     32, 1, 0, 0, 0, 0, -1,  8, 10};
        tbl[15] = '{"gap_lock",     1, 1, 0, 0, 1, 0, -1,  8, 10};
        tbl[16] = '{"gap_run",      8, 1, 0, 0, 1, 0, -1,  8, 14};
        bus.din = '0;
        bus.din_vld = 1'b0;
        bus.clr = 1'b0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 1, 1, 0, 0);
        chk("zeros_hunt", {63'd0, bus.locked}, 64'd0);
        for (int s = 0; s < 17; s++) begin
            for (int i = 0; i < tbl[s].n; i++)
                step(0, !tbl[s].gap || (i % 4 == 0) || (i % 4 == 3), 0, kind_mask(tbl[s].kind), tbl[s].clr);
            chk({tbl[s].name, ".locked"}, {63'd0, bus.locked}, {63'd0, tbl[s].lk});
            chk({tbl[s].name, ".err_pulse"}, {63'd0, bus.err_pulse}, {63'd0, tbl[s].pl});
            if (tbl[s].b >= 0) chk({tbl[s].name, ".bit_err_cnt"}, {32'd0, bus.bit_err_cnt}, tbl[s].b);
            chk({tbl[s].name, ".err_word_cnt"}, {32'd0, bus.err_word_cnt}, tbl[s].w);
            chk({tbl[s].name, ".word_cnt"}, {16'd0, bus.word_cnt}, tbl[s].wc);
        end
        step(0, 0, 0, 0, 0);
        force dut.bit_err_cnt_q = 32'hFFFF_FFF0;
        #1;
        release dut.bit_err_cnt_q;
        mb = 64'hFFFF_FFF0;
        step(0, 1, 0, 32'hFFFF_FFFF, 0);
        chk("sat_clamp", {32'd0, bus.bit_err_cnt}, 64'hFFFF_FFFF);
        step(0, 1, 0, 32'hFFFF_FFFF, 0);
        chk("sat_hold", {32'd0, bus.bit_err_cnt}, 64'hFFFF_FFFF);
        step(0, 1, 0, 0, 0);
        chk("pre_rst_locked", {63'd0, bus.locked}, 64'd1);
        step(1, 1, 0, 0, 0);
        chk("rst_locked", {63'd0, bus.locked}, 64'd0);
        chk("rst_counters", {bus.bit_err_cnt, bus.err_word_cnt | bus.word_cnt[31:0]}, 64'd0);
        step(0, 1, 0, 0, 0);
        chk("post_rst_hunt", {63'd0, bus.locked}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
